// File: rtl/imem_boot_loader.sv
// imem_boot_loader: assembles a little-endian host byte stream into instruction memory, then releases the core.
// Optional trailer checksum when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_boot_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic                  s_valid,
  input  logic [7:0]            s_data,
  output logic                  s_ready,
  input  logic                  cpu_re,
  input  logic [ADDR_WIDTH-1:0] cpu_raddr,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   words_loaded
);
  localparam int BPW = DATA_WIDTH / 8;
  localparam int BW = BPW > 1 ? $clog2(BPW) : 1;
  localparam int MEM_DEPTH = 2 ** ADDR_WIDTH;
`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, CSUM, RUN, ERROR} state_t;
  localparam state_t FIN = CSUM;
`else
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, RUN, ERROR} state_t;
  localparam state_t FIN = RUN;
`endif
  state_t state, nxt;
  logic [7:0] lo;
  logic [15:0] n, hdr;
  logic [BW-1:0] bcnt;
  logic [DATA_WIDTH-1:0] sh, word;
  logic hs, last;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] sum;
  assign s_ready = (state inside {HDR0, HDR1, DATA, CSUM}) && !load_start && !mem_we;
`else
  assign s_ready = (state inside {HDR0, HDR1, DATA}) && !load_start && !mem_we;
`endif
  assign hs = s_valid & s_ready;
  assign hdr = {s_data, lo};
  assign last = bcnt == BW'(BPW - 1);
  assign cpu_hold = state != RUN;
  assign load_error = state == ERROR;
  assign mem_re = (state == RUN) & cpu_re;
  assign mem_raddr = state == RUN ? cpu_raddr : '0;
  always_comb begin
    word = sh;
    word[{bcnt, 3'b000} +: 8] = s_data;
  end
  // The write cycle doubles as the completion check: words_loaded already counts the word being written.
  always_comb begin
    nxt = state;
    if (load_start) nxt = HDR0;
    else case (state)
      HDR0: nxt = hs ? HDR1 : HDR0;
      HDR1: nxt = !hs ? HDR1 : 32'(hdr) > 32'(MEM_DEPTH) ? ERROR : hdr == 16'd0 ? FIN : DATA;
      DATA: nxt = mem_we && 32'(words_loaded) == 32'(n) ? FIN : DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: nxt = !hs ? CSUM : 8'(sum + s_data) == 8'd0 ? RUN : ERROR;
`endif
      default: nxt = state;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      mem_we <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      words_loaded <= '0;
      load_done <= 1'b0;
      bcnt <= '0;
      lo <= '0;
      n <= '0;
      sh <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum <= '0;
`endif
    end else begin
      state <= nxt;
      load_done <= nxt == RUN && state != RUN;
      mem_we <= 1'b0;
      if (load_start) begin
        words_loaded <= '0;
        bcnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum <= '0;
`endif
      end else if (hs) begin
        if (state == HDR0) lo <= s_data;
        if (state == HDR1) n <= hdr;
        if (state == DATA) begin
          sh <= word;
          bcnt <= last ? '0 : bcnt + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum <= sum + s_data;
`endif
          if (last) begin
            mem_we <= 1'b1;
            mem_waddr <= words_loaded[ADDR_WIDTH-1:0];
            mem_wdata <= word;
            words_loaded <= words_loaded + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: stream-level model of the loader checked every cycle, plus literal spot checks.
module tb_imem_boot_loader;
  localparam int AW = 12;
  localparam int DEPTH = 4096;
  localparam int INF = 1 << 30;
  logic clock = 0, reset = 1, load_start = 0, s_valid = 0, cpu_re = 0;
  logic [7:0] s_data = 0;
  logic [AW-1:0] cpu_raddr = 0;
  logic s_ready, mem_re, mem_we, cpu_hold, load_done, load_error;
  logic [AW-1:0] mem_raddr, mem_waddr;
  logic [31:0] mem_wdata;
  logic [AW:0] words_loaded;

  imem_boot_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .load_start(load_start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .cpu_re(cpu_re), .cpu_raddr(cpu_raddr), .mem_re(mem_re), .mem_raddr(mem_raddr),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_error(load_error), .words_loaded(words_loaded));

  always #5 clock = ~clock;

  int total = 0, passed = 0, cyc = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Stream model: each accepted byte advances a byte count; effects are scheduled at the cycle the spec names.
  int run_from = INF, err_from = INF, write_at = -1, nb = 0, n_words = 0, wl = 0, exp_addr = 0, k = 0, done_cnt = 0;
  logic [31:0] acc = 0, exp_data = 0;
  logic [7:0] lo = 0, msum = 0;
  bit stream = 0, armed = 0, l_rst = 0, l_ls = 0, l_hs = 0;
  logic [7:0] l_b = 0;
  int wa[$];
  logic [31:0] wd[$];

  always @(negedge clock) begin
    cyc++;
    if (l_rst) begin
      armed = 1; stream = 0; run_from = INF; err_from = INF; write_at = -1; wl = 0; nb = 0; msum = 0;
    end else if (l_ls) begin
      stream = 1; run_from = INF; err_from = INF; wl = 0; nb = 0; msum = 0;
    end else if (l_hs) begin
      if (nb == 0) lo = l_b;
      else if (nb == 1) begin
        n_words = int'({l_b, lo});
        if (n_words > DEPTH) begin err_from = cyc; stream = 0; end
`ifndef IMEM_LOADER_CHECKSUM_EN
        else if (n_words == 0) begin run_from = cyc; stream = 0; end
`endif
      end else if (nb - 2 < n_words * 4) begin
        k = nb - 2;
        acc[(k % 4) * 8 +: 8] = l_b;
        msum += l_b;
        if (k % 4 == 3) begin
          write_at = cyc; exp_addr = k / 4; exp_data = acc; wl = k / 4 + 1;
`ifndef IMEM_LOADER_CHECKSUM_EN
          if (k / 4 == n_words - 1) begin run_from = cyc + 1; stream = 0; end
`endif
        end
      end else begin
        if (8'(msum + l_b) == 8'd0) run_from = cyc; else err_from = cyc;
        stream = 0;
      end
      nb++;
    end
    if (armed) begin
      chk("cpu_hold", 64'(cpu_hold), 64'(!(cyc >= run_from)));
      chk("load_done", 64'(load_done), 64'(cyc == run_from));
      chk("load_error", 64'(load_error), 64'(cyc >= err_from));
      chk("mem_we", 64'(mem_we), 64'(cyc == write_at));
      if (cyc == write_at) begin
        chk("mem_waddr", 64'(mem_waddr), 64'(exp_addr));
        chk("mem_wdata", 64'(mem_wdata), 64'(exp_data));
      end
      chk("words_loaded", 64'(words_loaded), 64'(wl));
      chk("mem_re", 64'(mem_re), 64'(cyc >= run_from && cpu_re));
      chk("mem_raddr", 64'(mem_raddr), cyc >= run_from ? 64'(cpu_raddr) : 64'(0));
      chk("s_ready", 64'(s_ready), 64'(stream && cyc != write_at && !load_start));
      if (mem_we === 1'b1) begin wa.push_back(int'(mem_waddr)); wd.push_back(mem_wdata); end
      if (load_done === 1'b1) done_cnt++;
    end
    l_rst = reset; l_ls = load_start; l_hs = s_valid && (s_ready === 1'b1); l_b = s_data;
  end

  logic [7:0] tsum = 0;
  task automatic tick(); @(posedge clock); #1; endtask
  task automatic pulse_start(); load_start = 1; tick(); load_start = 0; endtask
  task automatic send(input logic [7:0] b);
    bit ok = 0;
    s_valid = 1; s_data = b;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clock);
      ok = s_ready === 1'b1;
      tick();
    end
    s_valid = 0;
    if (!ok) begin total++; $display("FAIL send_timeout: byte %0h never accepted", b); end
  endtask
  task automatic send_hdr(input int n);
    logic [15:0] h;
    h = 16'(n); tsum = 0;
    send(h[7:0]); send(h[15:8]);
  endtask
  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin tsum += w[i*8 +: 8]; send(w[i*8 +: 8]); end
  endtask
  task automatic send_trailer();
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'(8'd0 - tsum));
`endif
  endtask

  int w0, d0;
  initial begin
    cpu_re = 1; cpu_raddr = 5;
    repeat (3) tick();
    reset = 0;
    repeat (20) tick();
    @(negedge clock);
    chk("pre_load_mem_re", 64'(mem_re), 64'(0));
    chk("idle_hold", 64'(cpu_hold), 64'(1));
    tick(); cpu_re = 0;
    w0 = wa.size(); d0 = done_cnt;
    pulse_start(); send_hdr(2); send_word(32'h0000_0013); send_word(32'h0010_0093); send_trailer();
    repeat (3) tick();
    @(negedge clock);
    chk("two_writes", 64'(wa.size() - w0), 64'(2));
    chk("w0_addr", 64'(wa[w0]), 64'(0));
    chk("w0_data", 64'(wd[w0]), 64'h13);
    chk("w1_addr", 64'(wa[w0+1]), 64'(1));
    chk("w1_data", 64'(wd[w0+1]), 64'h0010_0093);
    chk("wl_2", 64'(words_loaded), 64'(2));
    chk("one_done", 64'(done_cnt - d0), 64'(1));
    chk("run_hold", 64'(cpu_hold), 64'(0));
    tick(); cpu_re = 1; cpu_raddr = 5;
    @(negedge clock);
    chk("run_mem_re", 64'(mem_re), 64'(1));
    chk("run_mem_raddr", 64'(mem_raddr), 64'(5));
    tick(); cpu_re = 0;
    w0 = wa.size();
    pulse_start(); send(8'h01); send(8'h10);
    repeat (3) tick();
    @(negedge clock);
    chk("oversize_err", 64'(load_error), 64'(1));
    chk("oversize_hold", 64'(cpu_hold), 64'(1));
    chk("oversize_nowrite", 64'(wa.size() - w0), 64'(0));
    tick(); pulse_start();
    @(negedge clock);
    chk("err_cleared", 64'(load_error), 64'(0));
    tick();
    w0 = wa.size();
    send_hdr(3);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD); send(8'hEE);
    pulse_start(); send_hdr(1); send_word(32'h4433_2211); send_trailer();
    repeat (3) tick();
    @(negedge clock);
    chk("abort_writes", 64'(wa.size() - w0), 64'(2));
    chk("abort_w0", 64'(wd[w0]), 64'hDDCC_BBAA);
    chk("abort_w0_addr", 64'(wa[w0]), 64'(0));
    chk("new_w0", 64'(wd[w0+1]), 64'h4433_2211);
    chk("new_w0_addr", 64'(wa[w0+1]), 64'(0));
    chk("abort_wl", 64'(words_loaded), 64'(1));
    tick();
    pulse_start(); send_hdr(0); send_trailer();
    repeat (2) tick();
    @(negedge clock);
    chk("empty_run", 64'(cpu_hold), 64'(0));
    chk("empty_wl", 64'(words_loaded), 64'(0));
    tick();
    w0 = wa.size();
    pulse_start(); send_hdr(1); send(8'h01); send(8'h02); send(8'h03);
    s_valid = 1; s_data = 8'h04; reset = 1;
    tick();
    reset = 0; s_valid = 0;
    repeat (3) tick();
    @(negedge clock);
    chk("rst_nowrite", 64'(wa.size() - w0), 64'(0));
    chk("rst_hold", 64'(cpu_hold), 64'(1));
    chk("rst_wl", 64'(words_loaded), 64'(0));
    chk("rst_ready", 64'(s_ready), 64'(0));
    tick();
`ifdef IMEM_LOADER_CHECKSUM_EN
    pulse_start(); send(8'h01); send(8'h00); send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'hF6);
    repeat (3) tick();
    @(negedge clock);
    chk("csum_ok_run", 64'(cpu_hold), 64'(0));
    chk("csum_ok_err", 64'(load_error), 64'(0));
    tick();
    pulse_start(); send(8'h01); send(8'h00); send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'hF5);
    repeat (3) tick();
    @(negedge clock);
    chk("csum_bad_err", 64'(load_error), 64'(1));
    chk("csum_bad_hold", 64'(cpu_hold), 64'(1));
    tick();
`endif
    w0 = wa.size();
    pulse_start(); send_hdr(DEPTH);
    for (int w = 0; w < DEPTH; w++) send_word(32'(w) * 32'h9E37_79B1);
    send_trailer();
    repeat (3) tick();
    @(negedge clock);
    chk("full_wl", 64'(words_loaded), 64'(DEPTH));
    chk("full_writes", 64'(wa.size() - w0), 64'(DEPTH));
    chk("full_last_addr", 64'(wa[wa.size()-1]), 64'(DEPTH - 1));
    chk("full_run", 64'(cpu_hold), 64'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
